// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin scheduler that time-shares one dsc_mul stochastic multiplier.
// Optional RUN-state watchdog is compiled in when DSC_SCHED_TIMEOUT_EN is defined.
module dsc_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 6,
  parameter int TIMEOUT = 4200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       busy,
  output logic                       done,
  output logic [2*WIDTH-1:0]         result,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic                       err,
  output logic                       mul_rst,
  output logic                       mul_en,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic [2*WIDTH-1:0]         mul_z,
  input  logic                       mul_ov
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GNT_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLEAR   = 2'd1,
    ST_RUN     = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t             state_r, state_next_s;
  logic [IDW-1:0]     last_r, winner_r, pick_s, cand_s, result_id_r;
  logic               found_s, tmo_hit_s;
  logic [NUM_REQ-1:0] gnt_r, gnt_next_s;
  logic               busy_r, busy_next_s;
  logic               done_r, done_next_s;
  logic               mul_rst_r, mul_rst_next_s;
  logic               mul_en_r, mul_en_next_s;
  logic [WIDTH-1:0]   mul_a_r, mul_b_r;
  logic [2*WIDTH-1:0] result_r;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("dsc_mul_sched: unsupported NUM_REQ/TIMEOUT");
  end

  // round-robin search starting one past the last served requester
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s  = IDW'((int'(last_r) + i) % NUM_REQ);
      pick_s  = (!found_s && req[cand_s]) ? cand_s : pick_s;
      found_s = found_s | req[cand_s];
    end
  end

`ifdef DSC_SCHED_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_r;
  logic             err_r;

  // RUN-cycle counter, zero outside RUN so each operation starts fresh
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ST_RUN) begin
      tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
    end else begin
      tmo_cnt_r <= '0;
    end
  end

  assign tmo_hit_s = (state_r == ST_RUN) && !mul_ov &&
                     (tmo_cnt_r == TMO_W'(TIMEOUT - 1));

  // err is a pulse aligned with done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= (state_next_s == ST_CAPTURE) && tmo_hit_s;
    end
  end

  assign err = err_r;
`else
  assign tmo_hit_s = 1'b0;
  assign err       = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) state_next_s = ST_CLEAR;
        else         state_next_s = ST_IDLE;
      end
      ST_CLEAR: state_next_s = ST_RUN;
      ST_RUN: begin
        if (mul_ov || tmo_hit_s) state_next_s = ST_CAPTURE;
        else                     state_next_s = ST_RUN;
      end
      ST_CAPTURE: state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // outputs are decoded from the next state so they register in step with it
  always_comb begin
    gnt_next_s     = gnt_r;
    busy_next_s    = 1'b1;
    done_next_s    = 1'b0;
    mul_rst_next_s = 1'b1;
    mul_en_next_s  = 1'b0;
    case (state_next_s)
      ST_IDLE: begin
        gnt_next_s  = '0;
        busy_next_s = 1'b0;
      end
      ST_CLEAR:   gnt_next_s = GNT_ONE << pick_s;
      ST_RUN: begin
        mul_rst_next_s = 1'b0;
        mul_en_next_s  = 1'b1;
      end
      ST_CAPTURE: done_next_s = 1'b1;
      default: begin
        gnt_next_s  = '0;
        busy_next_s = 1'b0;
      end
    endcase
  end

  // control output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      mul_rst_r <= 1'b1;
      mul_en_r  <= 1'b0;
    end else begin
      gnt_r     <= gnt_next_s;
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      mul_rst_r <= mul_rst_next_s;
      mul_en_r  <= mul_en_next_s;
    end
  end

  // operands latch only at grant; product and owner latch on leaving RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_a_r     <= '0;
      mul_b_r     <= '0;
      winner_r    <= '0;
      result_r    <= '0;
      result_id_r <= '0;
      last_r      <= IDW'(NUM_REQ - 1);
    end else begin
      if (state_r == ST_IDLE && found_s) begin
        mul_a_r  <= req_a[int'(pick_s)*WIDTH +: WIDTH];
        mul_b_r  <= req_b[int'(pick_s)*WIDTH +: WIDTH];
        winner_r <= pick_s;
      end
      if (state_next_s == ST_CAPTURE) begin
        result_r    <= tmo_hit_s ? '0 : mul_z;
        result_id_r <= winner_r;
      end
      if (state_r == ST_CAPTURE) begin
        last_r <= winner_r;
      end
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign result    = result_r;
  assign result_id = result_id_r;
  assign mul_rst   = mul_rst_r;
  assign mul_en    = mul_en_r;
  assign mul_a     = mul_a_r;
  assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_dsc_mul_sched.sv
// Self-checking bench for dsc_mul_sched: behavioural multiplier plus a round-robin
// reference model; honours DSC_SCHED_TIMEOUT_EN for the stall scenario.
module tb_dsc_mul_sched;
  localparam int N = 4;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   gnt;
  logic           busy, done, err, mul_rst, mul_en, mul_ov;
  logic [2*W-1:0] result, mul_z;
  logic [1:0]     result_id;
  logic [W-1:0]   mul_a, mul_b;

  dsc_mul_sched #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(50)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .done(done), .result(result), .result_id(result_id),
    .err(err), .mul_rst(mul_rst), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_ov(mul_ov)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // behavioural multiplier: random run time, product valid once ov rises
  int   m_cnt, m_lat;
  logic m_ov;
  bit   ov_never = 1'b0;
  always @(posedge clk) begin
    if (mul_rst) begin
      m_cnt <= 0;
      m_ov  <= 1'b0;
      m_lat <= $urandom_range(1, 12);
    end else if (mul_en) begin
      m_cnt <= m_cnt + 1;
      m_ov  <= !ov_never && (m_cnt + 1 >= m_lat);
    end
  end
  assign mul_ov = m_ov;
  assign mul_z  = m_ov ? 12'(mul_a) * 12'(mul_b) : 12'hA5C;

  // reference model state
  logic [N-1:0] reqv;
  logic [W-1:0] a_m [N];
  logic [W-1:0] b_m [N];
  int           last_m;
  int           order [$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++)
      if (r[(last + i) % N]) return (last + i) % N;
    return 0;
  endfunction

  task automatic drive();
    req = reqv;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_m[i];
      req_b[i*W +: W] = b_m[i];
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_gnt", gnt, 0);          chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);        chk("rst_result", result, 0);
    chk("rst_id", result_id, 0);     chk("rst_err", err, 0);
    chk("rst_mul_rst", mul_rst, 1);  chk("rst_mul_en", mul_en, 0);
    chk("rst_mul_a", mul_a, 0);      chk("rst_mul_b", mul_b, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b0;
    reqv = '0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    last_m = N - 1;
  endtask

  // one full operation; na/nb < 0 means scribble random operands after grant
  task automatic serve_one(input logic [N-1:0] keep, input int na, input int nb);
    int             w, n;
    logic [N-1:0]   g;
    logic [2*W-1:0] exp_p;
    @(negedge clk);
    w = rr_pick(reqv, last_m);
    g = 4'b0001 << w;
    chk("gnt", gnt, g);
    chk("clr_mul_rst", mul_rst, 1);
    chk("clr_mul_en", mul_en, 0);
    chk("op_a", mul_a, a_m[w]);
    chk("op_b", mul_b, b_m[w]);
    exp_p  = 12'(a_m[w]) * 12'(b_m[w]);
    a_m[w] = (na < 0) ? 6'($urandom_range(0, 63)) : 6'(na);
    b_m[w] = (nb < 0) ? 6'($urandom_range(0, 63)) : 6'(nb);
    if (!keep[w]) reqv[w] = 1'b0;
    drive();
    @(negedge clk);
    chk("run_mul_rst", mul_rst, 0);
    chk("run_mul_en", mul_en, 1);
    chk("run_busy", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done", done, 1);
    chk("result", result, exp_p);
    chk("result_id", result_id, w);
    chk("err", err, 0);
    order.push_back(w);
    last_m = w;
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_busy", busy, 0);
    chk("result_hold", result, exp_p);
  endtask

  initial begin
    int  n;
    bit  seen;
    logic [N-1:0] kp;

    rst  = 1'b0;
    reqv = '0;
    for (int i = 0; i < N; i++) begin
      a_m[i] = '0;
      b_m[i] = '0;
    end
    drive();
    last_m = N - 1;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals();
    rst = 1'b1;

    // single request from requester 2
    reqv   = 4'b0100;
    a_m[2] = 6'd15;
    b_m[2] = 6'd15;
    drive();
    serve_one(4'b0000, -1, -1);
    chk("single_225", result, 225);
    chk("single_id", result_id, 2);

    // all four at once after reset: served 0,1,2,3
    do_reset();
    a_m[0] = 6'd3;  b_m[0] = 6'd5;
    a_m[1] = 6'd7;  b_m[1] = 6'd9;
    a_m[2] = 6'd63; b_m[2] = 6'd63;
    a_m[3] = 6'd0;  b_m[3] = 6'd12;
    reqv = 4'b1111;
    drive();
    order.delete();
    for (int k = 0; k < 4; k++) serve_one(4'b0000, -1, -1);
    for (int k = 0; k < 4; k++) chk("all4_order", order[k], k);
    chk("all4_last_result", result, 0);

    // fairness: 0 and 3 hold req continuously
    do_reset();
    a_m[0] = 6'($urandom_range(0, 63)); b_m[0] = 6'($urandom_range(0, 63));
    a_m[3] = 6'($urandom_range(0, 63)); b_m[3] = 6'($urandom_range(0, 63));
    reqv = 4'b1001;
    drive();
    order.delete();
    for (int k = 0; k < 4; k++) serve_one(4'b1001, -1, -1);
    reqv = '0;
    drive();
    chk("rr_0", order[0], 0); chk("rr_1", order[1], 3);
    chk("rr_2", order[2], 0); chk("rr_3", order[3], 3);

    // operand change right after grant must not affect the product
    reqv   = 4'b0010;
    a_m[1] = 6'd10;
    b_m[1] = 6'd20;
    drive();
    serve_one(4'b0000, 1, 1);
    chk("opchg_200", result, 200);

    // randomized traffic against the reference model
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!reqv[i]) begin
          a_m[i] = 6'($urandom_range(0, 63));
          b_m[i] = 6'($urandom_range(0, 63));
        end
      end
      reqv = reqv | 4'($urandom_range(0, 15));
      if (reqv == '0) reqv = 4'b0001 << $urandom_range(0, 3);
      drive();
      kp = 4'($urandom_range(0, 15));
      serve_one(kp, -1, -1);
    end
    reqv = '0;
    drive();

    // multiplier that never finishes
    do_reset();
    ov_never = 1'b1;
    reqv     = 4'b0100;
    drive();
    @(negedge clk);
    reqv = '0;
    drive();
    @(negedge clk);
    chk("stall_en", mul_en, 1);
`ifdef DSC_SCHED_TIMEOUT_EN
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 50);
    chk("tmo_err", err, 1);
    chk("tmo_result", result, 0);
    chk("tmo_id", result_id, 2);
`else
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("stall_no_done", seen, 0);
    chk("stall_busy", busy, 1);
`endif

    // asynchronous reset in the middle of RUN
    do_reset();
    reqv = 4'b1000;
    drive();
    @(negedge clk);
    reqv = '0;
    drive();
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_en", mul_en, 1);
    #1 rst = 1'b0;
    #1 check_reset_vals();
    ov_never = 1'b0;
    @(negedge clk);
    rst    = 1'b1;
    last_m = N - 1;
    seen   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("post_rst_no_done", seen, 0);
    reqv   = 4'b0001;
    a_m[0] = 6'($urandom_range(0, 63));
    b_m[0] = 6'($urandom_range(0, 63));
    drive();
    serve_one(4'b0000, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dsc_mul_sched.md
# dsc_mul_sched

Round-robin scheduler sharing one deterministic stochastic-computing multiplier (`dsc_mul`, 6-bit operands, 12-bit product, `ov` completion flag) among several requesters. Owns the multiplier's clear/enable sequencing: latches operands at grant, pulses the multiplier clear, holds enable until `ov`, captures `z`, and returns the product tagged with the requester index. Sits between the client datapaths and the single `dsc_mul` instance.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 6, operand width; product is 2*WIDTH
- `TIMEOUT`, 4200, RUN-state cycle limit (used only with `DSC_SCHED_TIMEOUT_EN`)

- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req`  in  NUM_REQ  per-requester request level
- `req_a`  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- `req_b`  in  NUM_REQ*WIDTH  operand B, same packing
- `gnt`  out  NUM_REQ  one-hot grant, held for the whole operation
- `busy`  out  1  high whenever state is not IDLE
- `done`  out  1  one-cycle pulse, `result`/`result_id` valid
- `result`  out  2*WIDTH  captured product
- `result_id`  out  $clog2(NUM_REQ)  index of requester that owns `result`
- `err`  out  1  valid with `done`; 1 = operation timed out
- `mul_rst`  out  1  active-high clear to multiplier
- `mul_en`  out  1  multiplier enable
- `mul_a`, `mul_b`  out  WIDTH  operands to multiplier
- `mul_z`  in  2*WIDTH  multiplier product
- `mul_ov`  in  1  multiplier finished

## Operation
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
- IDLE: if any `req` high, pick winner round-robin starting at index `last+1` (mod NUM_REQ); latch its `req_a`/`req_b` into `mul_a`/`mul_b`; set `gnt`; go CLEAR. No request: stay.
- CLEAR: `mul_rst`=1, `mul_en`=0, one cycle; go RUN.
- RUN: `mul_rst`=0, `mul_en`=1; on sampled `mul_ov`=1 latch `mul_z` into `result`, go CAPTURE.
- CAPTURE: `done`=1, `result_id`=winner, `mul_en`=0, `mul_rst`=1; `last`=winner; clear `gnt`; go IDLE.
- Operands are sampled only at grant; requester may change `req_a`/`req_b` after `gnt` rises.
- Dropping `req` mid-operation does not abort; result is still delivered.
- Requester must deassert `req` the cycle after its `done`; a `req` still high in the following IDLE cycle is a new request.
- Round-robin: a requester holding `req` continuously never waits more than NUM_REQ-1 other operations.
- `result` and `result_id` hold their values until the next CAPTURE.
- Outside RUN, `mul_ov` is ignored.

## Timing
- Reset values: `gnt`=0, `busy`=0, `done`=0, `result`=0, `result_id`=0, `err`=0, `mul_rst`=1, `mul_en`=0, `mul_a`=`mul_b`=0, `last`=NUM_REQ-1 (so requester 0 has first priority), state IDLE.
- `rst` low at any time, including mid-RUN: immediate return to reset values; in-flight operation discarded, no `done`.
- Request sampled in IDLE at cycle 0: `gnt`/CLEAR at cycle 1, `mul_en` first high cycle 2; `mul_ov` sampled at cycle n gives `done` at cycle n+1.
- Scheduler overhead: 3 cycles per operation plus multiplier run time; minimum `done`-to-next-`gnt` spacing is 2 cycles (CAPTURE, IDLE).
- Simultaneous requests resolved by round-robin pointer only, never by index order except after reset.

## Configuration
- `DSC_SCHED_TIMEOUT_EN` defined: a RUN-state cycle counter; if it reaches `TIMEOUT` without `mul_ov`, go CAPTURE with `result`=0, `err`=1, `done`=1; counter clears on entering RUN.
- Not defined: no counter; RUN waits indefinitely for `mul_ov`; `err` tied to 0; `TIMEOUT` unused.

## Test plan
- Single request: req[2]=1, a=15, b=15, behavioural multiplier model -> `gnt`=4'b0100, `mul_rst` pulse one cycle, `done` with result=225, result_id=2, err=0.
- All four requesting together after reset, operands (3,5),(7,9),(63,63),(0,12) -> grants in order 0,1,2,3, results 15,63,3969,0 with matching ids.
- Round-robin fairness: req[0] and req[3] held continuously -> grants alternate 0,3,0,3; neither starves.
- Operand change after grant: req[1] a=10,b=20, change to a=1,b=1 the cycle after `gnt` -> result=200.
- Reset mid-RUN: assert `rst` low during RUN -> all outputs to reset values immediately, no `done`; next request from requester 0 completes normally.
- With `DSC_SCHED_TIMEOUT_EN`, TIMEOUT=50, `mul_ov` never asserted -> `done` with err=1, result=0 exactly 50 RUN cycles after `mul_en` rises; without macro, `busy` stays high.
